// File: rtl/regdump_stream.sv
// rtl/regdump_stream.sv - snapshots the register file on start and streams it out word by word
// with a running additive checksum and a count of words sent.
module regdump_stream #(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [NREGS*XLEN-1:0] regs_flat,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4:0]            out_index,
    output logic [XLEN-1:0]       out_data,
    output logic                  busy,
    output logic                  done,
    output logic [XLEN-1:0]       checksum,
    output logic [5:0]            words_sent
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [4:0] IDX_LAST = 5'(NREGS - 1);

    state_t          state_q, state_d;
    logic [4:0]      idx_q, idx_d;
    logic [XLEN-1:0] snap_q [NREGS];
    logic [XLEN-1:0] snap_d [NREGS];
    logic [XLEN-1:0] checksum_q, checksum_d;
    logic [5:0]      words_sent_q, words_sent_d;
    logic [XLEN-1:0] cur;
    logic            emit;

    always_comb begin
        cur          = snap_q[idx_q];
        emit         = (state_q == S_SEND) && (!SKIP_ZERO || (cur != '0));
        state_d      = state_q;
        idx_d        = idx_q;
        snap_d       = snap_q;
        checksum_d   = checksum_q;
        words_sent_d = words_sent_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    for (int i = 0; i < NREGS; i++) begin
                        snap_d[i] = regs_flat[i*XLEN +: XLEN];
                    end
                    // Register 0 is hardwired zero in the core; ignore whatever the port shows.
                    snap_d[0]    = '0;
                    idx_d        = '0;
                    checksum_d   = '0;
                    words_sent_d = '0;
                    state_d      = S_SEND;
                end
            end
            S_SEND: begin
                // A skipped entry advances every cycle; an emitted one waits for the handshake.
                if (!emit || out_ready) begin
                    if (emit) begin
                        checksum_d   = checksum_q + cur;
                        words_sent_d = words_sent_q + 6'd1;
                    end
                    if (idx_q == IDX_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            snap_q       <= '{default: '0};
            checksum_q   <= '0;
            words_sent_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            checksum_q   <= checksum_d;
            words_sent_q <= words_sent_d;
        end
    end

    assign out_valid  = emit;
    assign out_index  = idx_q;
    assign out_data   = cur;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign checksum   = checksum_q;
    assign words_sent = words_sent_q;

endmodule

// File: doc/regdump_stream.md
Name: regdump_stream

Overview:
- Downstream consumer of the datapath's architectural register outputs (reg0..reg31).
- When the core signals end of program, takes a one-cycle snapshot of all registers.
- Streams the snapshot out one word per handshake on a valid/ready interface, for a UART/trace sink or a testbench scoreboard.
- Also accumulates a 32-bit additive checksum and a count of words sent.

Parameters:
- XLEN, 32, data width of each register word.
- NREGS, 32, number of registers captured and streamed; index width is 5 bits for the default.
- SKIP_ZERO, 0, when 1, registers whose snapshot value is zero are skipped and not emitted.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to snapshot and stream; driven by the core's end-of-program indication.
- regs_flat  input  NREGS*XLEN  register contents; bits [XLEN*i+XLEN-1 : XLEN*i] hold register i.
- out_valid  output  1  out_index/out_data hold a word to be accepted.
- out_ready  input  1  sink accepts the word this cycle when out_valid is also high.
- out_index  output  5  register number of the current word.
- out_data  output  XLEN  snapshot value of register out_index.
- busy  output  1  high from the cycle after start is accepted until the cycle after DONE.
- done  output  1  one-cycle pulse when the dump completes.
- checksum  output  XLEN  sum modulo 2^XLEN of all emitted words; held until the next start.
- words_sent  output  6  number of words emitted in the last or current dump (0..NREGS).

Behaviour:
- Reset (rst=1 at a rising edge) drives state=IDLE, out_valid=0, out_index=0, out_data=0, busy=0, done=0, checksum=0, words_sent=0, and clears the snapshot array. Reset mid-dump aborts the dump with no done pulse.
- States: IDLE, SEND, DONE.
- IDLE:
  - busy=0.
  - On start=1, at the same edge: copy regs_flat into the snapshot, forcing entry 0 to zero. Set idx=0, checksum=0, words_sent=0. Go to SEND.
- SEND, current entry nonzero or SKIP_ZERO=0:
  - out_valid=1, out_index=idx, out_data=snap[idx].
  - While out_ready=0, out_valid, out_index and out_data stay stable.
  - On out_valid && out_ready: checksum += snap[idx], words_sent += 1.
  - Then if idx==NREGS-1 go to DONE, else idx += 1.
- SEND, SKIP_ZERO=1 and snap[idx]==0:
  - out_valid=0.
  - idx advances by one per cycle, or the state goes to DONE if idx==NREGS-1.
  - checksum and words_sent are unchanged.
- DONE:
  - done=1 for exactly one cycle, out_valid=0, busy=1.
  - Next state IDLE.
  - checksum and words_sent are then held.
- Throughput: one word per cycle when out_ready is held high.
  - SKIP_ZERO=0: start at edge T; first word valid in the cycle after T; last handshake at edge T+32; done high in the cycle after T+32.
- start while busy or in DONE is ignored. The snapshot is not updated, so regs_flat changes during a dump do not affect the output.
- Simultaneous rst and start: reset wins.
- checksum wraps modulo 2^XLEN with no overflow flag.
- All-zero snapshot with SKIP_ZERO=1: no word is emitted, done pulses after NREGS cycles, checksum=0, words_sent=0.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, start=0 -> all outputs 0, out_valid never asserts.
- Full dump with SKIP_ZERO=0, regs_flat[i]=i*4 (reg0 input 0xFFFFFFFF), out_ready=1, start pulse -> 32 consecutive words with index 0..31 and data 0,4,...,124 (reg0 emitted as 0). done pulses in the cycle after the 32nd handshake. checksum=0x7C0, words_sent=32.
- Backpressure: same stimulus with out_ready toggling 1,0,0,1 repeating -> no word dropped or duplicated, data stable during stalls, same checksum 0x7C0.
- Skip zero with SKIP_ZERO=1: only reg5=0x10 and reg31=0xFFFFFFF0 nonzero -> exactly two words, (5,0x10) then (31,0xFFFFFFF0). checksum=0x00000000 (wraparound), words_sent=2.
- Snapshot isolation and ignored start: change regs_flat and pulse start mid-dump -> emitted data equals the values at the original start, and no restart occurs.
- Reset mid-operation: assert rst after the 10th handshake -> next cycle out_valid=0, busy=0, checksum=0, no done pulse. A subsequent start performs a full, correct dump.
